// File: rtl/memory_pkg.sv
// Shared encodings for the memory initiator: FSM states, byte-lane masks and
// the request fields captured at acceptance.
package memory_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_LOW  = 2'b01;
  localparam logic [1:0] MASK_HIGH = 2'b10;
  localparam logic [1:0] MASK_WORD = 2'b11;

  // Request attributes still needed after acceptance; the full address and
  // write data live in the bus_address/bus_data_out registers.
  typedef struct packed {
    logic write;
    logic byte_op;
    logic sign_extend;
    logic addr_lsb;
  } req_t;

endpackage

// File: rtl/byte_lane.sv
// Byte-lane steering: write data replication and mask generation, plus read
// lane selection with optional sign extension.
module byte_lane
  import memory_pkg::*;
(
  input  logic        byte_op,
  input  logic        addr_lsb,
  input  logic        sign_extend,
  input  logic [15:0] wdata,
  input  logic [15:0] bus_data_in,
  output logic [15:0] wr_data,
  output logic [1:0]  wr_mask,
  output logic [15:0] rd_data
);

  logic [7:0] lane;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_data = wdata;
    wr_mask = MASK_WORD;
    rd_data = bus_data_in;
    lane    = addr_lsb ? bus_data_in[15:8] : bus_data_in[7:0];
    if (byte_op) begin
      wr_data = {wdata[7:0], wdata[7:0]};
      wr_mask = addr_lsb ? MASK_HIGH : MASK_LOW;
      rd_data = {(sign_extend ? {8{lane[7]}} : 8'h00), lane};
    end
  end

endmodule

// File: rtl/memory_initiator.sv
// CPU-to-memory bus initiator: word/byte reads and writes with a fixed number
// of read wait states and a fault response to misaligned word accesses.
module memory_initiator
  import memory_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        write,
  input  logic        byte_op,
  input  logic        sign_extend,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        fault,
  output logic [15:0] rdata,
  output logic [15:0] bus_address,
  output logic [15:0] bus_data_out,
  output logic [1:0]  bus_write_mask,
  output logic        bus_enable,
  output logic        bus_write_enable,
  input  logic [15:0] bus_data_in
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

  logic [1:0]  state;
  logic [2:0]  count;
  req_t        cur;
  logic        lane_byte_op;
  logic        lane_lsb;
  logic [15:0] lane_wdata;
  logic [1:0]  lane_mask;
  logic [15:0] lane_rdata;

  assign ready = (state == ST_IDLE);

  // In IDLE the lanes are steered from the incoming request so the bus
  // registers load directly; afterwards the captured attributes drive the read side.
  assign lane_byte_op = ready ? byte_op : cur.byte_op;
  assign lane_lsb     = ready ? addr[0] : cur.addr_lsb;

  byte_lane u_byte_lane (
    .byte_op     (lane_byte_op),
    .addr_lsb    (lane_lsb),
    .sign_extend (cur.sign_extend),
    .wdata       (wdata),
    .bus_data_in (bus_data_in),
    .wr_data     (lane_wdata),
    .wr_mask     (lane_mask),
    .rd_data     (lane_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      count            <= '0;
      cur              <= '0;
      done             <= 1'b0;
      fault            <= 1'b0;
      rdata            <= '0;
      bus_address      <= '0;
      bus_data_out     <= '0;
      bus_write_mask   <= MASK_NONE;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            cur   <= '{write: write, byte_op: byte_op,
                       sign_extend: sign_extend, addr_lsb: addr[0]};
            count <= '0;
            if (!byte_op && addr[0]) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              state            <= ST_ACCESS;
              bus_enable       <= 1'b1;
              bus_write_enable <= write;
              bus_address      <= {addr[15:1], 1'b0};
              bus_write_mask   <= lane_mask;
              if (write) bus_data_out <= lane_wdata;
            end
          end
        end
        ST_ACCESS: begin
          if (cur.write || count == WAIT_LAST) begin
            state            <= ST_IDLE;
            done             <= 1'b1;
            bus_enable       <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_write_mask   <= MASK_NONE;
            if (!cur.write) rdata <= lane_rdata;
          end else begin
            count <= count + 3'd1;
          end
        end
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_initiator.sv
// Directed bench for memory_initiator: a scoreboard of expected completions is
// filled as requests are issued and drained as done/fault pulses appear.
module tb_memory_initiator;

  localparam int WS = 3;

  typedef struct {
    logic        is_fault;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, write, byte_op, sign_extend;
  logic [15:0] addr, wdata, bus_data_in;

  logic        ready, done, fault, bus_enable, bus_write_enable;
  logic [15:0] rdata, bus_address, bus_data_out;
  logic [1:0]  bus_write_mask;

  logic        ready0, done0, fault0, bus_enable0, bus_write_enable0;
  logic [15:0] rdata0, bus_address0, bus_data_out0;
  logic [1:0]  bus_write_mask0;

  exp_t        sb[$];
  logic [15:0] model_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  memory_initiator #(.WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req(req), .write(write), .byte_op(byte_op),
    .sign_extend(sign_extend), .addr(addr), .wdata(wdata), .ready(ready),
    .done(done), .fault(fault), .rdata(rdata), .bus_address(bus_address),
    .bus_data_out(bus_data_out), .bus_write_mask(bus_write_mask),
    .bus_enable(bus_enable), .bus_write_enable(bus_write_enable),
    .bus_data_in(bus_data_in)
  );

  memory_initiator #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .write(write), .byte_op(byte_op),
    .sign_extend(sign_extend), .addr(addr), .wdata(wdata), .ready(ready0),
    .done(done0), .fault(fault0), .rdata(rdata0), .bus_address(bus_address0),
    .bus_data_out(bus_data_out0), .bus_write_mask(bus_write_mask0),
    .bus_enable(bus_enable0), .bus_write_enable(bus_write_enable0),
    .bus_data_in(bus_data_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_expect(output exp_t e);
    n_checks++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d entries expected >0", sb.size());
    end
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.is_fault = 1'b0;
      e.rdata    = model_rdata;
    end
  endtask

  // Issue one request, follow it to completion and score it.
  task automatic do_access(input logic wr, input logic bop, input logic sext,
                           input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] din);
    exp_t        e;
    int          cycles;
    logic        is_fault;
    logic [15:0] exp_addr, exp_data;
    logic [1:0]  exp_mask;
    logic [7:0]  lane;

    is_fault = !bop && a[0];
    exp_addr = {a[15:1], 1'b0};
    exp_mask = !bop ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    exp_data = bop ? {wd[7:0], wd[7:0]} : wd;
    e.is_fault = is_fault;
    e.rdata    = model_rdata;
    if (!is_fault && !wr) begin
      lane = a[0] ? din[15:8] : din[7:0];
      e.rdata = bop ? {(sext ? {8{lane[7]}} : 8'h00), lane} : din;
    end
    sb.push_back(e);
    model_rdata = e.rdata;

    @(negedge clk);
    check("ready_before", ready, 1);
    req = 1'b1; write = wr; byte_op = bop; sign_extend = sext;
    addr = a; wdata = wd; bus_data_in = din;
    @(negedge clk);
    req = 1'b0;

    if (is_fault) begin
      check("fault_pulse", fault, 1);
      check("fault_no_done", done, 0);
      check("fault_no_bus_enable", bus_enable, 0);
      check("fault_not_ready", ready, 0);
      pop_expect(e);
      check("fault_sb_kind", fault, e.is_fault);
      check("fault_rdata_held", rdata, e.rdata);
      @(negedge clk);
      check("fault_ready_back", ready, 1);
      check("fault_one_cycle", fault, 0);
      check("fault_no_bus_enable_after", bus_enable, 0);
    end else begin
      cycles = 0;
      for (int i = 0; i < 20 && !done; i++) begin
        if (bus_enable) begin
          cycles++;
          if (cycles == 1) begin
            check("bus_address", bus_address, exp_addr);
            check("bus_write_enable", bus_write_enable, wr);
            if (wr) begin
              check("bus_write_mask", bus_write_mask, exp_mask);
              check("bus_data_out", bus_data_out, exp_data);
            end
          end
        end
        @(negedge clk);
      end
      check("done_seen", done, 1);
      check("access_cycles", cycles, wr ? 1 : WS + 1);
      check("done_not_with_fault", fault, 0);
      check("idle_bus_enable", bus_enable, 0);
      check("idle_write_enable", bus_write_enable, 0);
      check("idle_mask", bus_write_mask, 0);
      check("idle_address_hold", bus_address, exp_addr);
      pop_expect(e);
      check("done_sb_kind", fault, e.is_fault);
      check("rdata", rdata, e.rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req = 1'b0; write = 1'b0; byte_op = 1'b0; sign_extend = 1'b0;
    addr = '0; wdata = '0; bus_data_in = '0; model_rdata = '0;

    // Reset state and first cycle after release
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bus_enable", bus_enable, 0);
    check("rst_bus_address", bus_address, 0);
    check("rst_bus_data_out", bus_data_out, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ready, 1);

    do_access(1'b1, 1'b0, 1'b0, 16'h8002, 16'h1234, 16'h0000);  // word write
    do_access(1'b1, 1'b1, 1'b0, 16'hC005, 16'h00AB, 16'h0000);  // byte write, high lane
    do_access(1'b1, 1'b1, 1'b0, 16'h0010, 16'hFF56, 16'h0000);  // byte write, low lane
    do_access(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'h80FF);  // -> FF80
    do_access(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h80FF);  // -> 0080
    do_access(1'b0, 1'b1, 1'b1, 16'h0002, 16'h0000, 16'h12F0);  // -> FFF0
    do_access(1'b0, 1'b0, 1'b0, 16'h4002, 16'h0000, 16'hBEEF);  // word read
    do_access(1'b0, 1'b0, 1'b0, 16'h4003, 16'h0000, 16'h5555);  // misaligned read
    do_access(1'b1, 1'b0, 1'b0, 16'h0001, 16'h9999, 16'h0000);  // misaligned write

    // Reset in the middle of a read access
    @(negedge clk);
    req = 1'b1; write = 1'b0; byte_op = 1'b0; addr = 16'h0300; bus_data_in = 16'h5A5A;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("mid_read_bus_enable", bus_enable, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_bus_enable", bus_enable, 0);
    check("abort_bus_address", bus_address, 0);
    check("abort_rdata", rdata, 0);
    check("abort_done", done, 0);
    check("abort_ready", ready, 1);
    model_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < WS + 2; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    do_access(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hCAFE);

    // Reset during a write access drops the write strobe without a clock
    @(negedge clk);
    req = 1'b1; write = 1'b1; byte_op = 1'b1; addr = 16'h0200; wdata = 16'h0077;
    @(negedge clk);
    req = 1'b0;
    check("mid_write_strobe", bus_write_enable, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_write_strobe", bus_write_enable, 0);
    check("abort_write_mask", bus_write_mask, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_write_no_done", done, 0);

    // Zero wait states with req held: one access every two cycles
    @(negedge clk);
    req = 1'b1; write = 1'b0; byte_op = 1'b0; addr = 16'h0400; bus_data_in = 16'h1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_bus_enable", bus_enable0, (i % 2) == 0);
      check("b2b_done", done0, (i % 2) == 1);
      check("b2b_ready", ready0, (i % 2) == 1);
      if (done0) check("b2b_rdata", rdata0, 16'h1111);
    end
    req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_initiator.md
MEMORY_INITIATOR -- requirements
Module: memory_initiator

Interface
REQ-001 Parameter: WAIT_STATES, default 1, bus cycles from address valid to read data valid (legal 0..7).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  CPU access request; sampled only while ready=1.
REQ-005 write  input  1  1=write, 0=read; sampled with req.
REQ-006 byte_op  input  1  1=byte access, 0=word access.
REQ-007 sign_extend  input  1  byte reads only: 1=sign-extend bit 7, 0=zero-extend.
REQ-008 addr  input  16  CPU byte address.
REQ-009 wdata  input  16  write data; byte writes use wdata[7:0].
REQ-010 ready  output  1  high only in IDLE; request may be accepted.
REQ-011 done  output  1  one-cycle pulse on successful completion.
REQ-012 fault  output  1  one-cycle pulse on odd-address word access.
REQ-013 rdata  output  16  read result; holds until next read completes.
REQ-014 bus_address  output  16  word-aligned address to memory bus (bit 0 always 0).
REQ-015 bus_data_out  output  16  write data to memory bus.
REQ-016 bus_write_mask  output  2  byte-lane enables, bit1=high byte, bit0=low byte.
REQ-017 bus_enable  output  1  bus access strobe.
REQ-018 bus_write_enable  output  1  bus write strobe.
REQ-019 bus_data_in  input  16  read data from memory bus.

Function
REQ-020 States SHALL be IDLE, ACCESS, FAULT; ready = (state==IDLE).
REQ-021 Acceptance: req=1 at a rising edge in IDLE latches write, byte_op, sign_extend, addr, wdata.
REQ-022 Word access with addr[0]=1 SHALL go IDLE->FAULT, drive no bus strobes, pulse fault one cycle in FAULT, then return to IDLE.
REQ-023 Otherwise IDLE->ACCESS; during ACCESS bus_enable=1, bus_address={addr[15:1],0}.
REQ-024 Write mask: word=2'b11; byte with addr[0]=0 -> 2'b01; byte with addr[0]=1 -> 2'b10.
REQ-025 Write data: word=wdata; byte={wdata[7:0],wdata[7:0]}.
REQ-026 Write: ACCESS lasts exactly 1 cycle with bus_write_enable=1; next edge -> IDLE with done=1 for that one cycle.
REQ-027 Read: bus_write_enable=0; ACCESS lasts WAIT_STATES+1 cycles (3-bit counter); at the last edge rdata captured from bus_data_in, -> IDLE with done=1.
REQ-028 Byte read: lane = addr[0] ? bus_data_in[15:8] : bus_data_in[7:0]; upper byte = sign_extend ? {8{lane[7]}} : 8'h00.
REQ-029 Outside ACCESS: bus_enable=0, bus_write_enable=0, bus_write_mask=2'b00; bus_address and bus_data_out hold last value.
REQ-030 req while ready=0 SHALL be ignored (not queued); back-to-back accepted requests occupy consecutive IDLE cycles (done and next acceptance may coincide).
REQ-031 done and fault SHALL never be high simultaneously; at most one per accepted request.

Reset
REQ-032 reset low SHALL asynchronously force: state=IDLE, counter=0, rdata=0, done=0, fault=0, all bus outputs 0.
REQ-033 Reset mid-ACCESS SHALL abort the access immediately (bus_write_enable drops without waiting for clk) and SHALL produce no done.
REQ-034 After reset release, ready=1 in the first cycle.

Structure
REQ-035 Shared package memory_pkg holds state encodings and write-mask constants (MASK_WORD, MASK_LOW, MASK_HIGH).
REQ-036 One sub-module byte_lane: combinational write-lane replication/mask generation and read-lane select/extension.
REQ-037 All outputs except ready SHALL be registered.

Verification
REQ-038 Word write addr=0x8002 wdata=0x1234 -> one ACCESS cycle, bus_address=0x8002, mask=2'b11, bus_write_enable=1, done next cycle.
REQ-039 Byte write addr=0xC005 wdata=0x00AB -> bus_address=0xC004, bus_data_out=0xABAB, mask=2'b10.
REQ-040 Byte read addr=0x0001, bus_data_in=0x80FF, sign_extend=1 -> rdata=0xFF80; sign_extend=0 -> 0x0080; done after WAIT_STATES+1 ACCESS cycles.
REQ-041 Word read addr=0x4003 -> fault pulse, bus_enable never asserted, rdata unchanged, ready back to 1 in two cycles.
REQ-042 Reset asserted during read ACCESS with WAIT_STATES=3 -> outputs 0 immediately, no done; next read completes normally.
REQ-043 req held high continuously with WAIT_STATES=0 -> one access per two cycles, requests during ACCESS ignored.
